// File: rtl/arch_rfl_pkg.sv
// Shared rename-stage constants and the modulo-depth pointer helper used by
// both the architectural and speculative free lists.
package arch_rfl_pkg;

  localparam int NUM_PR   = 80;
  localparam int NUM_AR   = 32;
  localparam int FL_DEPTH = NUM_PR - NUM_AR;
  localparam int TAG_W    = 7;
  localparam int PTR_W    = 6;
  localparam int CNT_W    = 6;
  localparam int RET_W    = 8;
  localparam int SUM_W    = 4;

  localparam logic [PTR_W:0] FL_DEPTH_L = (PTR_W+1)'(FL_DEPTH);

  // p + n wrapped into 0..FL_DEPTH-1; valid for p < FL_DEPTH and n < FL_DEPTH
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                                input logic [PTR_W:0]   n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + n;
    if (s >= FL_DEPTH_L) s = s - FL_DEPTH_L;
    return s[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/rfl_ptr_adv.sv
// Prefix-count pointer advance: each valid slot gets base plus the number of
// valid slots below it, wrapped modulo the list depth.
module rfl_ptr_adv
  import arch_rfl_pkg::*;
(
  input  logic [PTR_W-1:0]            base,
  input  logic [RET_W-1:0]            vld,
  output logic [RET_W-1:0][PTR_W-1:0] idx,
  output logic [PTR_W-1:0]            new_ptr,
  output logic [SUM_W-1:0]            count
);

  logic [SUM_W-1:0] acc;

  always_comb begin
    acc = '0;
    idx = '0;
    for (int s = 0; s < RET_W; s++) begin
      idx[s] = ptr_inc(base, {3'b000, acc});
      acc    = acc + SUM_W'(vld[s]);
    end
    count   = acc;
    new_ptr = ptr_inc(base, {3'b000, acc});
  end

endmodule

// File: rtl/arch_rfl.sv
// Architectural free register list: retirement-only circular list that
// forwards released tags and exposes a head-first snapshot for recovery.
module arch_rfl
  import arch_rfl_pkg::*;
#(
  parameter int NPR = NUM_PR,
  parameter int NAR = NUM_AR,
  parameter int RW  = RET_W
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         retire0_alloc_i,
  input  logic                         retire1_alloc_i,
  input  logic                         retire2_alloc_i,
  input  logic                         retire3_alloc_i,
  input  logic                         retire4_alloc_i,
  input  logic                         retire5_alloc_i,
  input  logic                         retire6_alloc_i,
  input  logic                         retire7_alloc_i,
  input  logic [TAG_W-1:0]             retire0_old_pd_i,
  input  logic [TAG_W-1:0]             retire1_old_pd_i,
  input  logic [TAG_W-1:0]             retire2_old_pd_i,
  input  logic [TAG_W-1:0]             retire3_old_pd_i,
  input  logic [TAG_W-1:0]             retire4_old_pd_i,
  input  logic [TAG_W-1:0]             retire5_old_pd_i,
  input  logic [TAG_W-1:0]             retire6_old_pd_i,
  input  logic [TAG_W-1:0]             retire7_old_pd_i,
  input  logic                         retire0_old_pd_vld_i,
  input  logic                         retire1_old_pd_vld_i,
  input  logic                         retire2_old_pd_vld_i,
  input  logic                         retire3_old_pd_vld_i,
  input  logic                         retire4_old_pd_vld_i,
  input  logic                         retire5_old_pd_vld_i,
  input  logic                         retire6_old_pd_vld_i,
  input  logic                         retire7_old_pd_vld_i,
  input  logic                         flush_i,
  output logic [TAG_W-1:0]             retire0_rls_rd_o,
  output logic [TAG_W-1:0]             retire1_rls_rd_o,
  output logic [TAG_W-1:0]             retire2_rls_rd_o,
  output logic [TAG_W-1:0]             retire3_rls_rd_o,
  output logic [TAG_W-1:0]             retire4_rls_rd_o,
  output logic [TAG_W-1:0]             retire5_rls_rd_o,
  output logic [TAG_W-1:0]             retire6_rls_rd_o,
  output logic [TAG_W-1:0]             retire7_rls_rd_o,
  output logic                         retire0_rls_rd_vld_o,
  output logic                         retire1_rls_rd_vld_o,
  output logic                         retire2_rls_rd_vld_o,
  output logic                         retire3_rls_rd_vld_o,
  output logic                         retire4_rls_rd_vld_o,
  output logic                         retire5_rls_rd_vld_o,
  output logic                         retire6_rls_rd_vld_o,
  output logic                         retire7_rls_rd_vld_o,
  output logic                         arch_fl_rec_o,
  output logic [(NPR-NAR)*TAG_W-1:0]   arch_fl_rec_data_o,
  output logic [CNT_W-1:0]             free_cnt_o,
  output logic                         err_o
);

  localparam int DEPTH = NPR - NAR;

  logic [RW-1:0]             alloc;
  logic [RW-1:0]             pd_vld;
  logic [RW-1:0][TAG_W-1:0]  old_pd;

  logic [TAG_W-1:0]          mem [DEPTH];
  logic [PTR_W-1:0]          head_ptr, tail_ptr;
  logic [CNT_W-1:0]          cnt;
  logic                      err_q;

  logic [RW-1:0][PTR_W-1:0]  push_idx;
  logic [RW-1:0][PTR_W-1:0]  pop_idx_unused;
  logic [PTR_W-1:0]          head_nxt, tail_nxt;
  logic [SUM_W-1:0]          pop_cnt, push_cnt;
  logic [CNT_W:0]            cnt_next;
  logic                      underflow, overflow, err_cyc;

  logic [RW-1:0][TAG_W-1:0]  rls_rd_q;
  logic [RW-1:0]             rls_vld_q;
  logic                      rec_q;

  assign alloc  = {retire7_alloc_i, retire6_alloc_i, retire5_alloc_i, retire4_alloc_i,
                   retire3_alloc_i, retire2_alloc_i, retire1_alloc_i, retire0_alloc_i};
  assign pd_vld = {retire7_old_pd_vld_i, retire6_old_pd_vld_i, retire5_old_pd_vld_i,
                   retire4_old_pd_vld_i, retire3_old_pd_vld_i, retire2_old_pd_vld_i,
                   retire1_old_pd_vld_i, retire0_old_pd_vld_i};
  assign old_pd = {retire7_old_pd_i, retire6_old_pd_i, retire5_old_pd_i, retire4_old_pd_i,
                   retire3_old_pd_i, retire2_old_pd_i, retire1_old_pd_i, retire0_old_pd_i};

  rfl_ptr_adv u_pop_adv (
    .base    (head_ptr),
    .vld     (alloc),
    .idx     (pop_idx_unused),
    .new_ptr (head_nxt),
    .count   (pop_cnt)
  );

  rfl_ptr_adv u_push_adv (
    .base    (tail_ptr),
    .vld     (pd_vld),
    .idx     (push_idx),
    .new_ptr (tail_nxt),
    .count   (push_cnt)
  );

  // An underflowed difference wraps high at 7 bits, so overflow also catches it
  assign cnt_next  = {1'b0, cnt} + (CNT_W+1)'(push_cnt) - (CNT_W+1)'(pop_cnt);
  assign underflow = (CNT_W+1)'(pop_cnt) > {1'b0, cnt};
  assign overflow  = cnt_next > (CNT_W+1)'(DEPTH);
  assign err_cyc   = underflow | overflow;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(NAR + i);
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= CNT_W'(DEPTH);
      err_q    <= 1'b0;
    end else begin
      if (!err_cyc) begin
        head_ptr <= head_nxt;
        tail_ptr <= tail_nxt;
        cnt      <= cnt_next[CNT_W-1:0];
        for (int s = 0; s < RW; s++) begin
          if (pd_vld[s]) mem[push_idx[s]] <= old_pd[s];
        end
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rls_rd_q  <= '0;
      rls_vld_q <= '0;
      rec_q     <= 1'b0;
    end else begin
      rls_rd_q  <= old_pd;
      rls_vld_q <= pd_vld;
      rec_q     <= flush_i;
    end
  end

  always_comb begin
    arch_fl_rec_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      arch_fl_rec_data_o[k*TAG_W +: TAG_W] = mem[ptr_inc(head_ptr, (PTR_W+1)'(k))];
    end
  end

  assign retire0_rls_rd_o     = rls_rd_q[0];
  assign retire1_rls_rd_o     = rls_rd_q[1];
  assign retire2_rls_rd_o     = rls_rd_q[2];
  assign retire3_rls_rd_o     = rls_rd_q[3];
  assign retire4_rls_rd_o     = rls_rd_q[4];
  assign retire5_rls_rd_o     = rls_rd_q[5];
  assign retire6_rls_rd_o     = rls_rd_q[6];
  assign retire7_rls_rd_o     = rls_rd_q[7];
  assign retire0_rls_rd_vld_o = rls_vld_q[0];
  assign retire1_rls_rd_vld_o = rls_vld_q[1];
  assign retire2_rls_rd_vld_o = rls_vld_q[2];
  assign retire3_rls_rd_vld_o = rls_vld_q[3];
  assign retire4_rls_rd_vld_o = rls_vld_q[4];
  assign retire5_rls_rd_vld_o = rls_vld_q[5];
  assign retire6_rls_rd_vld_o = rls_vld_q[6];
  assign retire7_rls_rd_vld_o = rls_vld_q[7];
  assign arch_fl_rec_o        = rec_q;
  assign free_cnt_o           = cnt;
  assign err_o                = err_q;

endmodule

// File: tb/tb_arch_rfl.sv
// Self-checking bench for arch_rfl: directed scenarios plus constrained random
// retirement checked against a queue model of the committed free list.
module tb_arch_rfl;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   alloc, vld;
  logic [6:0]   pd [8];
  logic         flush;
  logic [6:0]   rls_rd [8];
  logic [7:0]   rls_vld;
  logic         rec;
  logic [335:0] rec_data;
  logic [5:0]   free_cnt;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  int         q[$];
  bit         m_err;
  logic [6:0] ex_pd [8];
  logic [7:0] ex_vld;
  logic       ex_rec;

  always #5 clock = ~clock;

  arch_rfl dut (
    .clock(clock), .reset_n(reset_n),
    .retire0_alloc_i(alloc[0]), .retire1_alloc_i(alloc[1]), .retire2_alloc_i(alloc[2]),
    .retire3_alloc_i(alloc[3]), .retire4_alloc_i(alloc[4]), .retire5_alloc_i(alloc[5]),
    .retire6_alloc_i(alloc[6]), .retire7_alloc_i(alloc[7]),
    .retire0_old_pd_i(pd[0]), .retire1_old_pd_i(pd[1]), .retire2_old_pd_i(pd[2]),
    .retire3_old_pd_i(pd[3]), .retire4_old_pd_i(pd[4]), .retire5_old_pd_i(pd[5]),
    .retire6_old_pd_i(pd[6]), .retire7_old_pd_i(pd[7]),
    .retire0_old_pd_vld_i(vld[0]), .retire1_old_pd_vld_i(vld[1]), .retire2_old_pd_vld_i(vld[2]),
    .retire3_old_pd_vld_i(vld[3]), .retire4_old_pd_vld_i(vld[4]), .retire5_old_pd_vld_i(vld[5]),
    .retire6_old_pd_vld_i(vld[6]), .retire7_old_pd_vld_i(vld[7]),
    .flush_i(flush),
    .retire0_rls_rd_o(rls_rd[0]), .retire1_rls_rd_o(rls_rd[1]), .retire2_rls_rd_o(rls_rd[2]),
    .retire3_rls_rd_o(rls_rd[3]), .retire4_rls_rd_o(rls_rd[4]), .retire5_rls_rd_o(rls_rd[5]),
    .retire6_rls_rd_o(rls_rd[6]), .retire7_rls_rd_o(rls_rd[7]),
    .retire0_rls_rd_vld_o(rls_vld[0]), .retire1_rls_rd_vld_o(rls_vld[1]),
    .retire2_rls_rd_vld_o(rls_vld[2]), .retire3_rls_rd_vld_o(rls_vld[3]),
    .retire4_rls_rd_vld_o(rls_vld[4]), .retire5_rls_rd_vld_o(rls_vld[5]),
    .retire6_rls_rd_vld_o(rls_vld[6]), .retire7_rls_rd_vld_o(rls_vld[7]),
    .arch_fl_rec_o(rec), .arch_fl_rec_data_o(rec_data),
    .free_cnt_o(free_cnt), .err_o(err)
  );

  task automatic clear_in();
    alloc = '0; vld = '0; flush = 1'b0;
    for (int s = 0; s < 8; s++) pd[s] = '0;
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 48; i++) q.push_back(32 + i);
    m_err = 1'b0;
    for (int s = 0; s < 8; s++) ex_pd[s] = '0;
    ex_vld = '0; ex_rec = 1'b0;
  endtask

  // Apply the current inputs to the model and let the DUT take one edge
  task automatic tick();
    int p, n;
    p = $countones(alloc);
    n = $countones(vld);
    for (int s = 0; s < 8; s++) ex_pd[s] = pd[s];
    ex_vld = vld;
    ex_rec = flush;
    if (p > q.size() || q.size() + n - p > 48) m_err = 1'b1;
    else begin
      repeat (p) void'(q.pop_front());
      for (int s = 0; s < 8; s++) if (vld[s]) q.push_back(int'(pd[s]));
    end
    @(posedge clock); #1;
  endtask

  function automatic int snap_bad();
    for (int k = 0; k < q.size(); k++)
      if (rec_data[7*k +: 7] !== 7'(q[k])) return k;
    return -1;
  endfunction

  function automatic logic [7:0] rand_mask(int n);
    logic [7:0] m;
    m = '0;
    while ($countones(m) < n) m[$urandom_range(0, 7)] = 1'b1;
    return m;
  endfunction

  task automatic refill();
    int n;
    while (q.size() < 48) begin
      clear_in();
      n = 48 - q.size();
      if (n > 8) n = 8;
      vld = rand_mask(n);
      for (int s = 0; s < 8; s++) pd[s] = 7'($urandom_range(0, 127));
      tick();
    end
    clear_in();
  endtask

  task automatic test_reset();
    int bad;
    clear_in();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
    n_tests++; if (free_cnt !== 6'd48) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 48", free_cnt); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    bad = -1;
    for (int k = 0; k < 48; k++) if (bad < 0 && rec_data[7*k +: 7] !== 7'(32 + k)) bad = k;
    n_tests++; if (bad != -1) begin n_fail++; $display("FAIL reset_snap: entry %0d got %0d expected %0d", bad, rec_data[7*bad +: 7], 32 + bad); end
    bad = 0;
    for (int s = 0; s < 8; s++) if (rls_rd[s] !== 7'd0) bad++;
    n_tests++; if (rls_vld !== 8'd0 || rec !== 1'b0 || bad != 0) begin n_fail++; $display("FAIL reset_rls: vld %h rec %b nonzero_rd %0d expected all 0", rls_vld, rec, bad); end
  endtask

  task automatic test_slot0();
    clear_in();
    alloc[0] = 1'b1; vld[0] = 1'b1; pd[0] = 7'd5;
    tick(); clear_in();
    n_tests++; if (free_cnt !== 6'd48) begin n_fail++; $display("FAIL slot0_cnt: got %0d expected 48", free_cnt); end
    n_tests++; if (rls_rd[0] !== 7'd5 || rls_vld !== 8'h01) begin n_fail++; $display("FAIL slot0_rls: rd %0d vld %h expected 5 01", rls_rd[0], rls_vld); end
    n_tests++; if (rec_data[6:0] !== 7'd33) begin n_fail++; $display("FAIL slot0_head: got %0d expected 33", rec_data[6:0]); end
    n_tests++; if (rec_data[335:329] !== 7'd5) begin n_fail++; $display("FAIL slot0_tail: got %0d expected 5", rec_data[335:329]); end
    n_tests++; if (snap_bad() != -1) begin n_fail++; $display("FAIL slot0_snap: first bad entry %0d", snap_bad()); end
  endtask

  task automatic test_sparse_push();
    clear_in(); alloc = 8'h07;
    tick(); clear_in();
    n_tests++; if (free_cnt !== 6'd45) begin n_fail++; $display("FAIL sparse_pop_cnt: got %0d expected 45", free_cnt); end
    vld = 8'h4A; pd[1] = 7'd10; pd[3] = 7'd11; pd[6] = 7'd12;
    tick(); clear_in();
    n_tests++; if (free_cnt !== 6'd48) begin n_fail++; $display("FAIL sparse_cnt: got %0d expected 48", free_cnt); end
    n_tests++; if (rls_vld !== 8'h4A || rls_rd[1] !== 7'd10 || rls_rd[3] !== 7'd11 || rls_rd[6] !== 7'd12)
      begin n_fail++; $display("FAIL sparse_rls: vld %h rd1 %0d rd3 %0d rd6 %0d expected 4a 10 11 12", rls_vld, rls_rd[1], rls_rd[3], rls_rd[6]); end
    n_tests++; if (rec_data[7*45 +: 7] !== 7'd10 || rec_data[7*46 +: 7] !== 7'd11 || rec_data[7*47 +: 7] !== 7'd12)
      begin n_fail++; $display("FAIL sparse_order: got %0d %0d %0d expected 10 11 12", rec_data[7*45 +: 7], rec_data[7*46 +: 7], rec_data[7*47 +: 7]); end
    n_tests++; if (snap_bad() != -1) begin n_fail++; $display("FAIL sparse_snap: first bad entry %0d", snap_bad()); end
  endtask

  task automatic test_wrap();
    // head = tail = 4 here; seven 6-wide cycles bring both to 46
    repeat (7) begin
      clear_in(); alloc = 8'h3F; vld = 8'h3F;
      for (int s = 0; s < 6; s++) pd[s] = 7'($urandom_range(0, 127));
      tick();
    end
    clear_in(); alloc = 8'h0F; vld = 8'h0F;
    for (int s = 0; s < 4; s++) pd[s] = 7'(20 + s);
    tick(); clear_in();
    n_tests++; if (free_cnt !== 6'd48) begin n_fail++; $display("FAIL wrap_cnt: got %0d expected 48", free_cnt); end
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (rec_data[7*(44+k) +: 7] !== 7'(20 + k)) begin n_fail++; $display("FAIL wrap_entry%0d: got %0d expected %0d", 44 + k, rec_data[7*(44+k) +: 7], 20 + k); end
    end
    n_tests++; if (snap_bad() != -1) begin n_fail++; $display("FAIL wrap_snap: first bad entry %0d", snap_bad()); end
  endtask

  task automatic test_random();
    int np, nq, hi, bad;
    for (int it = 0; it < 200; it++) begin
      clear_in();
      hi = (q.size() < 8) ? q.size() : 8;
      np = $urandom_range(0, hi);
      hi = 48 - q.size() + np; if (hi > 8) hi = 8;
      nq = $urandom_range(0, hi);
      alloc = rand_mask(np);
      vld   = rand_mask(nq);
      for (int s = 0; s < 8; s++) pd[s] = 7'($urandom_range(0, 127));
      flush = ($urandom_range(0, 7) == 0);
      tick(); clear_in();
      n_tests++; if (free_cnt !== 6'(q.size()) || err !== m_err) begin n_fail++; $display("FAIL rand_cnt it%0d: cnt %0d err %b expected %0d %b", it, free_cnt, err, q.size(), m_err); end
      bad = 0;
      for (int s = 0; s < 8; s++) if (rls_rd[s] !== ex_pd[s]) bad++;
      n_tests++; if (bad != 0 || rls_vld !== ex_vld || rec !== ex_rec) begin n_fail++; $display("FAIL rand_rls it%0d: vld %h rec %b bad_rd %0d expected vld %h rec %b", it, rls_vld, rec, bad, ex_vld, ex_rec); end
      n_tests++; if (snap_bad() != -1) begin n_fail++; $display("FAIL rand_snap it%0d: first bad entry %0d", it, snap_bad()); end
    end
  endtask

  task automatic test_flush();
    logic [6:0] t0, t1;
    refill();
    t0 = 7'($urandom_range(0, 127)); t1 = 7'($urandom_range(0, 127));
    alloc = 8'h03; vld = 8'h03; pd[0] = t0; pd[1] = t1; flush = 1'b1;
    tick(); clear_in();
    n_tests++; if (rec !== 1'b1) begin n_fail++; $display("FAIL flush_rec: got %b expected 1", rec); end
    n_tests++; if (rec_data[7*46 +: 7] !== t0 || rec_data[7*47 +: 7] !== t1)
      begin n_fail++; $display("FAIL flush_tail: got %0d %0d expected %0d %0d", rec_data[7*46 +: 7], rec_data[7*47 +: 7], t0, t1); end
    n_tests++; if (snap_bad() != -1) begin n_fail++; $display("FAIL flush_snap: first bad entry %0d", snap_bad()); end
    tick();
    n_tests++; if (rec !== 1'b0) begin n_fail++; $display("FAIL flush_rec_drop: got %b expected 0", rec); end
  endtask

  task automatic test_overflow();
    refill();
    vld[2] = 1'b1; pd[2] = 7'd9;
    tick(); clear_in();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", err); end
    n_tests++; if (free_cnt !== 6'd48) begin n_fail++; $display("FAIL ovf_cnt: got %0d expected 48", free_cnt); end
    n_tests++; if (rls_vld !== 8'h04 || rls_rd[2] !== 7'd9) begin n_fail++; $display("FAIL ovf_rls: vld %h rd %0d expected 04 9", rls_vld, rls_rd[2]); end
    n_tests++; if (snap_bad() != -1) begin n_fail++; $display("FAIL ovf_snap: first bad entry %0d", snap_bad()); end
    alloc = 8'h01; vld = 8'h80; pd[7] = 7'd77;
    tick(); clear_in();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", err); end
    n_tests++; if (snap_bad() != -1) begin n_fail++; $display("FAIL ovf_after_snap: first bad entry %0d", snap_bad()); end
  endtask

  task automatic test_reset_mid();
    int bad;
    clear_in(); alloc = 8'h01; vld = 8'h01; pd[0] = 7'd99; flush = 1'b1;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    n_tests++; if (rls_vld !== 8'd0 || rls_rd[0] !== 7'd0 || rec !== 1'b0) begin n_fail++; $display("FAIL rstmid_out: vld %h rd %0d rec %b expected 0", rls_vld, rls_rd[0], rec); end
    n_tests++; if (free_cnt !== 6'd48 || err !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: cnt %0d err %b expected 48 0", free_cnt, err); end
    bad = -1;
    for (int k = 0; k < 48; k++) if (bad < 0 && rec_data[7*k +: 7] !== 7'(32 + k)) bad = k;
    n_tests++; if (bad != -1) begin n_fail++; $display("FAIL rstmid_snap: entry %0d got %0d expected %0d", bad, rec_data[7*bad +: 7], 32 + bad); end
    clear_in();
    @(posedge clock); #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_underflow();
    clear_in();
    repeat (6) begin alloc = 8'hFF; tick(); end
    clear_in();
    n_tests++; if (free_cnt !== 6'd0 || err !== 1'b0) begin n_fail++; $display("FAIL unf_empty: cnt %0d err %b expected 0 0", free_cnt, err); end
    alloc = 8'h03; vld = 8'h01; pd[0] = 7'd44;
    tick(); clear_in();
    n_tests++; if (err !== 1'b1 || free_cnt !== 6'd0) begin n_fail++; $display("FAIL unf_err: err %b cnt %0d expected 1 0", err, free_cnt); end
    n_tests++; if (rls_vld !== 8'h01 || rls_rd[0] !== 7'd44) begin n_fail++; $display("FAIL unf_rls: vld %h rd %0d expected 01 44", rls_vld, rls_rd[0]); end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clear_in();
    test_reset();
    test_slot0();
    test_sparse_push();
    test_wrap();
    test_random();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_underflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
